// File: rtl/stage_sequencer_if.sv
// Handshake and status bundle between the stage sequencer and its datapath/memories.
// CNT_WID must match the sequencer's CNT_WID.
interface stage_sequencer_if #(
    parameter int CNT_WID = 32
);
    logic               run;
    logic [3:0]         icode;
    logic               imem_ack;
    logic               imem_error;
    logic               dmem_ack;
    logic               dmem_error;
    logic               imem_req;
    logic               dmem_req;
    logic               decode_en;
    logic               exec_en;
    logic               wb_en;
    logic               pc_en;
    logic [2:0]         stat;
    logic [CNT_WID-1:0] cycle_cnt;
    logic [CNT_WID-1:0] instr_cnt;

    modport master (
        input  run, icode, imem_ack, imem_error, dmem_ack, dmem_error,
        output imem_req, dmem_req, decode_en, exec_en, wb_en, pc_en,
        output stat, cycle_cnt, instr_cnt
    );

    modport slave (
        output run, icode, imem_ack, imem_error, dmem_ack, dmem_error,
        input  imem_req, dmem_req, decode_en, exec_en, wb_en, pc_en,
        input  stat, cycle_cnt, instr_cnt
    );
endinterface

// File: rtl/stage_sequencer.sv
// Multi-cycle Y86 stage sequencer: FETCH..PCUPDATE with memory handshakes, status and counters.
// Optional macro STAGE_SKIP_EN lets simple instructions bypass MEMORY and/or WRITEBACK.
module stage_sequencer #(
    parameter int CNT_WID = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    stage_sequencer_if.master  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_PC, S_HALT
    } state_t;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    state_t             state_q, state_d;
    logic [2:0]         stat_q, stat_d;
    logic [3:0]         icode_q;
    logic [CNT_WID-1:0] cycle_q, instr_q;
    logic               skip_mem, skip_wb;
    logic               imem_req, dmem_req, decode_en, exec_en, wb_en, pc_en;

`ifdef STAGE_SKIP_EN
    always_comb begin
        skip_mem = icode_q inside {4'd1, 4'd2, 4'd3, 4'd6, 4'd7};
        skip_wb  = icode_q inside {4'd1, 4'd4, 4'd7};
    end
`else
    logic unused_icode;
    assign unused_icode = ^icode_q;
    assign skip_mem     = 1'b0;
    assign skip_wb      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            stat_q  <= STAT_AOK;
            icode_q <= '0;
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            stat_q  <= stat_d;
            if (state_q == S_DECODE)
                icode_q <= bus.icode;
            if (state_q != S_IDLE && state_q != S_HALT)
                cycle_q <= cycle_q + 1'b1;
            if (state_q == S_PC)
                instr_q <= instr_q + 1'b1;
        end
    end

    // Enables are pure decodes of the state, so at most one can be high per cycle.
    always_comb begin
        state_d   = state_q;
        stat_d    = stat_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        decode_en = 1'b0;
        exec_en   = 1'b0;
        wb_en     = 1'b0;
        pc_en     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.run)
                    state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (bus.imem_ack) begin
                    if (bus.imem_error) begin
                        state_d = S_HALT;
                        stat_d  = STAT_ADR;
                    end else begin
                        state_d = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                decode_en = 1'b1;
                if (bus.icode == 4'h0) begin
                    state_d = S_HALT;
                    stat_d  = STAT_HLT;
                end else if (bus.icode > 4'hB) begin
                    state_d = S_HALT;
                    stat_d  = STAT_INS;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                exec_en = 1'b1;
                if (!skip_mem)
                    state_d = S_MEM;
                else if (!skip_wb)
                    state_d = S_WB;
                else
                    state_d = S_PC;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                if (bus.dmem_ack) begin
                    if (bus.dmem_error) begin
                        state_d = S_HALT;
                        stat_d  = STAT_ADR;
                    end else begin
                        state_d = skip_wb ? S_PC : S_WB;
                    end
                end
            end
            S_WB: begin
                wb_en   = 1'b1;
                state_d = S_PC;
            end
            S_PC: begin
                pc_en   = 1'b1;
                state_d = bus.run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.imem_req  = imem_req;
    assign bus.dmem_req  = dmem_req;
    assign bus.decode_en = decode_en;
    assign bus.exec_en   = exec_en;
    assign bus.wb_en     = wb_en;
    assign bus.pc_en     = pc_en;
    assign bus.stat      = stat_q;
    assign bus.cycle_cnt = cycle_q;
    assign bus.instr_cnt = instr_q;
endmodule
